microsequencer: RTL and testbench
=================================

# microsequencer

Next-state sequencer for the microprogrammed MIPS control unit. Holds the current control state, feeds it to the microstore each cycle, and computes the next state from the microstore's next-state fields, the instruction encoder's target state, and status conditions (memory-operation-complete, ALU flags, branch condition). Supports one-level micro-subroutine call/return and a memory-wait watchdog. Sits between the instruction encoder / status logic and the microstore address input.

## Interface
- STATE_W, 7, width of the state number
- NUM_STATES, 50, number of implemented states; legal states are 0..NUM_STATES-1
- TIMEOUT_CYCLES, 16, consecutive self-loop cycles before the watchdog fires (used only with the watchdog macro)

- clk  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-high
- n_sel  in  3  next-state select, from the microstore
- cond_sel  in  2  condition select, from the microstore
- cond_inv  in  1  invert the selected condition, from the microstore
- cr_state  in  STATE_W  jump-target field, from the microstore
- enc_state  in  STATE_W  decoded-instruction target state, from the instruction encoder
- moc  in  1  memory operation complete
- alu_zero  in  1  ALU zero flag
- alu_neg  in  1  ALU sign flag
- br_cond  in  1  branch condition from the condition tester
- state  out  STATE_W  current state, to the microstore address input
- illegal_state  out  1  one-cycle pulse when a computed next state was out of range
- bus_error  out  1  one-cycle pulse when the watchdog fires (watchdog builds only)

## Operation
- Condition: cond_sel 00=moc, 01=alu_zero, 10=alu_neg, 11=br_cond. cond = selected XOR cond_inv.
- Incrementer value: inc = state+1, modulo 2^STATE_W (127 wraps to 0).
- n_sel selects the next state:
  - 000: enc_state.
  - 001: 0, the fetch state.
  - 010: cr_state.
  - 011: inc.
  - 100: cond ? cr_state : inc.
  - 101: cond ? cr_state : enc_state.
  - 110: call. Next state is cr_state; ret_reg <= inc.
  - 111: return. Next state is ret_reg.
- ret_reg is STATE_W wide and has one level only. A second call overwrites it. A return with no prior call goes to ret_reg's reset value, 0.
- Range check: a computed next state >= NUM_STATES is replaced with 0, and illegal_state pulses high in the cycle the register loads 0.
- Memory wait idiom: a state with n_sel=100, cond_sel=00, cond_inv=1 and cr_state equal to its own number loops while moc is low. It advances to inc in the first cycle moc is sampled high.

## Timing
- All state updates happen on the rising edge of clk. Next-state computation is combinational from the current inputs.
- The microstore is combinational from state, so its fields are valid in the same cycle. Latency from a field to the new state is one cycle.
- On reset the following are loaded: state=0, ret_reg=0, illegal_state=0, bus_error=0, watchdog counter=0.
- Reset takes priority over every other event, including a call in progress, a memory wait, or a watchdog expiry in the same cycle.
- illegal_state and bus_error are registered pulses, each exactly one cycle long.

## Configuration
- Macro: MICROSEQ_WATCHDOG_EN.
- Defined:
  - A counter of width clog2(TIMEOUT_CYCLES+1) increments every cycle the computed next state equals the current state. Any change of state clears it.
  - When the counter reaches TIMEOUT_CYCLES, the next state is forced to 0 (overriding n_sel), bus_error pulses for one cycle, and the counter clears.
  - If moc is sampled high on the expiry cycle, the watchdog still wins.
- Undefined:
  - No counter is built. bus_error is tied to 0.
  - Self-loops wait indefinitely.

## Structure
- Package microseq_pkg holds:
  - the n_sel encodings: NS_ENC, NS_FETCH, NS_CR, NS_INC, NS_CR_INC, NS_CR_ENC, NS_CALL, NS_RET;
  - the cond_sel encodings: CS_MOC, CS_ZERO, CS_NEG, CS_BR;
  - STATE_FETCH=0.
- One sub-module: microseq_cond_mux, the condition select plus invert (purely combinational). The next-state mux, ret_reg, range check and watchdog live in the top module.

## Test plan
- Reset: hold reset for 2 cycles with n_sel=011 → state=0, illegal_state=0, bus_error=0. Release → state=1 on the next edge.
- Encoder dispatch: state 4, n_sel=000, enc_state=16 → state 16 after one edge. enc_state=60 → state 0 and a one-cycle illegal_state pulse.
- Memory wait: state 7, n_sel=100, cond_sel=00, cond_inv=1, cr_state=7. moc low for 3 cycles → state stays 7. moc high → state 8 on the next edge.
- Conditional branch: n_sel=101, cond_sel=01, alu_zero=1, cr_state=30 → state 30. With alu_zero=0 and enc_state=20 → state 20.
- Call/return: state 12, n_sel=110, cr_state=40 → state 40, ret_reg=13. Then n_sel=111 → state 13.
- Watchdog (MICROSEQ_WATCHDOG_EN defined, TIMEOUT_CYCLES=16): self-loop on state 7 with moc held low → state returns to 0 after 16 loop cycles, and bus_error is high for exactly one cycle. Built without the macro → state stays at 7 indefinitely.

Source files
------------

// File: rtl/microseq_pkg.sv
// Shared encodings for the MIPS control-unit microsequencer.
// Microstore field encodings and the fetch state number.
package microseq_pkg;

  typedef enum logic [2:0] {
    NS_ENC    = 3'b000,
    NS_FETCH  = 3'b001,
    NS_CR     = 3'b010,
    NS_INC    = 3'b011,
    NS_CR_INC = 3'b100,
    NS_CR_ENC = 3'b101,
    NS_CALL   = 3'b110,
    NS_RET    = 3'b111
  } nsel_e;

  typedef enum logic [1:0] {
    CS_MOC  = 2'b00,
    CS_ZERO = 2'b01,
    CS_NEG  = 2'b10,
    CS_BR   = 2'b11
  } csel_e;

  localparam int STATE_FETCH = 0;

endpackage

// File: rtl/microseq_cond_mux.sv
// Status-condition select with optional inversion.
// Purely combinational; feeds the conditional next-state selects.
module microseq_cond_mux
  import microseq_pkg::*;
(
  input  logic [1:0] cond_sel,
  input  logic       cond_inv,
  input  logic       moc,
  input  logic       alu_zero,
  input  logic       alu_neg,
  input  logic       br_cond,
  output logic       cond
);

  logic sel;

  always_comb begin
    sel = moc;
    unique case (cond_sel)
      CS_MOC:  sel = moc;
      CS_ZERO: sel = alu_zero;
      CS_NEG:  sel = alu_neg;
      CS_BR:   sel = br_cond;
      default: sel = moc;
    endcase
  end

  assign cond = sel ^ cond_inv;

endmodule

// File: rtl/microsequencer.sv
// Next-state sequencer for the microprogrammed control unit.
// Define MICROSEQ_WATCHDOG_EN to build the memory-wait watchdog.
module microsequencer
  import microseq_pkg::*;
#(
  parameter int STATE_W        = 7,
  parameter int NUM_STATES     = 50,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2:0]         n_sel,
  input  logic [1:0]         cond_sel,
  input  logic               cond_inv,
  input  logic [STATE_W-1:0] cr_state,
  input  logic [STATE_W-1:0] enc_state,
  input  logic               moc,
  input  logic               alu_zero,
  input  logic               alu_neg,
  input  logic               br_cond,
  output logic [STATE_W-1:0] state,
  output logic               illegal_state,
  output logic               bus_error
);

  localparam logic [STATE_W-1:0] FETCH = STATE_W'(STATE_FETCH);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  logic               cond;
  logic [STATE_W-1:0] inc;
  logic [STATE_W-1:0] raw_next;
  logic [STATE_W-1:0] legal_next;
  logic [STATE_W-1:0] ret_reg;
  logic               out_range;
  logic               wd_fire;

  microseq_cond_mux u_cond (
    .cond_sel (cond_sel),
    .cond_inv (cond_inv),
    .moc      (moc),
    .alu_zero (alu_zero),
    .alu_neg  (alu_neg),
    .br_cond  (br_cond),
    .cond     (cond)
  );

  assign inc = state + STATE_W'(1);

  always_comb begin
    raw_next = inc;
    unique case (n_sel)
      NS_ENC:    raw_next = enc_state;
      NS_FETCH:  raw_next = FETCH;
      NS_CR:     raw_next = cr_state;
      NS_INC:    raw_next = inc;
      NS_CR_INC: raw_next = cond ? cr_state : inc;
      NS_CR_ENC: raw_next = cond ? cr_state : enc_state;
      NS_CALL:   raw_next = cr_state;
      NS_RET:    raw_next = ret_reg;
      default:   raw_next = inc;
    endcase
  end

  assign out_range  = raw_next >= STATE_W'(NUM_STATES);
  assign legal_next = out_range ? FETCH : raw_next;

`ifdef MICROSEQ_WATCHDOG_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wd_cnt;

  assign wd_fire = wd_cnt == CNT_W'(TIMEOUT_CYCLES);

  // Counts consecutive cycles the sequencer sits on one state.
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt    <= '0;
      bus_error <= 1'b0;
    end else begin
      bus_error <= wd_fire;
      if (wd_fire || legal_next != state)
        wd_cnt <= '0;
      else
        wd_cnt <= wd_cnt + CNT_W'(1);
    end
  end
`else
  assign wd_fire   = 1'b0;
  assign bus_error = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= FETCH;
      ret_reg       <= '0;
      illegal_state <= 1'b0;
    end else begin
      illegal_state <= out_range && !wd_fire;
      state         <= wd_fire ? FETCH : legal_next;
      if (n_sel == NS_CALL && !wd_fire)
        ret_reg <= inc;
    end
  end

endmodule

// File: tb/tb_microsequencer.sv
// Self-checking bench for the microsequencer.
// Directed test-plan sequences followed by randomized microstore fields.
module tb_microsequencer;

  localparam int NUM     = 50;
  localparam int TIMEOUT = 16;

  logic       clk;
  logic       reset;
  logic [2:0] n_sel;
  logic [1:0] cond_sel;
  logic       cond_inv;
  logic [6:0] cr_state;
  logic [6:0] enc_state;
  logic       moc;
  logic       alu_zero;
  logic       alu_neg;
  logic       br_cond;
  logic [6:0] state;
  logic       illegal_state;
  logic       bus_error;

  int n_checks = 0;
  int n_fail   = 0;

  int m_state, m_ret, m_ill, m_bus, m_cnt;

  microsequencer dut (
    .clk           (clk),
    .reset         (reset),
    .n_sel         (n_sel),
    .cond_sel      (cond_sel),
    .cond_inv      (cond_inv),
    .cr_state      (cr_state),
    .enc_state     (enc_state),
    .moc           (moc),
    .alu_zero      (alu_zero),
    .alu_neg       (alu_neg),
    .br_cond       (br_cond),
    .state         (state),
    .illegal_state (illegal_state),
    .bus_error     (bus_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input int ns, input int cs, input int ci,
                       input int cr, input int enc);
    n_sel     = 3'(ns);
    cond_sel  = 2'(cs);
    cond_inv  = 1'(ci);
    cr_state  = 7'(cr);
    enc_state = 7'(enc);
  endtask

  // Reference: applies one clock of the sequencing rules, then compares.
  task automatic step();
    int raw, nxt, inc;
    bit c, fire;
    logic [3:0] fl;
    fl  = {br_cond, alu_neg, alu_zero, moc};
    c   = fl[cond_sel] ^ cond_inv;
    inc = (m_state + 1) % 128;
    if (reset) begin
      m_state = 0; m_ret = 0; m_ill = 0; m_bus = 0; m_cnt = 0;
    end else begin
      fire = 1'b0;
`ifdef MICROSEQ_WATCHDOG_EN
      fire = (m_cnt == TIMEOUT);
`endif
      if (fire) begin
        m_state = 0; m_ill = 0; m_bus = 1; m_cnt = 0;
      end else begin
        raw = inc;
        case (int'(n_sel))
          0: raw = int'(enc_state);
          1: raw = 0;
          2: raw = int'(cr_state);
          3: raw = inc;
          4: raw = c ? int'(cr_state) : inc;
          5: raw = c ? int'(cr_state) : int'(enc_state);
          6: begin raw = int'(cr_state); m_ret = inc; end
          default: raw = m_ret;
        endcase
        m_ill = (raw >= NUM) ? 1 : 0;
        nxt   = m_ill ? 0 : raw;
        m_cnt = (nxt == m_state) ? m_cnt + 1 : 0;
        m_bus = 0;
        m_state = nxt;
      end
    end
    @(posedge clk);
    #1;
    check("state", int'(state), m_state);
    check("illegal_state", int'(illegal_state), m_ill);
    check("bus_error", int'(bus_error), m_bus);
  endtask

  initial begin
    m_state = 0; m_ret = 0; m_ill = 0; m_bus = 0; m_cnt = 0;
    reset = 1'b1;
    moc = 0; alu_zero = 0; alu_neg = 0; br_cond = 0;
    drive(3, 0, 0, 0, 0);
    step();
    step();
    check("reset_state", int'(state), 0);
    reset = 1'b0;
    step();
    check("release_inc", int'(state), 1);

    drive(2, 0, 0, 4, 0); step();
    drive(0, 0, 0, 0, 16); step();
    check("dispatch", int'(state), 16);
    drive(0, 0, 0, 0, 60); step();
    check("dispatch_oob", int'(state), 0);
    check("illegal_pulse", int'(illegal_state), 1);
    drive(3, 0, 0, 0, 0); step();
    check("illegal_clear", int'(illegal_state), 0);

    drive(2, 0, 0, 7, 0); step();
    drive(4, 0, 1, 7, 0);
    moc = 0;
    repeat (3) step();
    check("mem_wait", int'(state), 7);
    moc = 1; step();
    check("mem_done", int'(state), 8);
    moc = 0;

    drive(5, 1, 0, 30, 20);
    alu_zero = 1; step();
    check("br_taken", int'(state), 30);
    alu_zero = 0; step();
    check("br_not_taken", int'(state), 20);

    drive(2, 0, 0, 12, 0); step();
    drive(6, 0, 0, 40, 0); step();
    check("call", int'(state), 40);
    drive(7, 0, 0, 0, 0); step();
    check("return", int'(state), 13);

    drive(2, 0, 0, 7, 0); step();
    drive(4, 0, 1, 7, 0);
    moc = 0;
    repeat (TIMEOUT) step();
    check("wd_loop", int'(state), 7);
    step();
`ifdef MICROSEQ_WATCHDOG_EN
    check("wd_fire_state", int'(state), 0);
    check("wd_fire_bus", int'(bus_error), 1);
`else
    check("no_wd_state", int'(state), 7);
    check("no_wd_bus", int'(bus_error), 0);
`endif
    step();
    check("bus_pulse_end", int'(bus_error), 0);

    for (int i = 0; i < 600; i++) begin
      reset    = ($urandom_range(0, 59) == 0);
      n_sel    = 3'($urandom_range(0, 7));
      cond_sel = 2'($urandom_range(0, 3));
      cond_inv = 1'($urandom_range(0, 1));
      cr_state = 7'($urandom_range(0, 63));
      enc_state = 7'(($urandom_range(0, 7) == 0) ?
                     $urandom_range(0, 127) : $urandom_range(0, 49));
      moc      = 1'($urandom_range(0, 1));
      alu_zero = 1'($urandom_range(0, 1));
      alu_neg  = 1'($urandom_range(0, 1));
      br_cond  = 1'($urandom_range(0, 1));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
